// File: rtl/raycast_column_writer.sv
// Producer side of the double-buffered column-height store.
// Fills the back buffer one column at a time and swaps on frame start.
module raycast_column_writer #(
    parameter int NUM_COLS   = 640,
    parameter int MAX_HEIGHT = 960
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_start,
    input  logic       i_col_valid,
    input  logic [9:0] i_col_height,
    output logic       o_col_ready,
    output logic [9:0] o_col_x,
    output logic       o_wr_en1,
    output logic       o_wr_en2,
    output logic [9:0] o_wr_addr,
    output logic [9:0] o_wr_data,
    output logic       o_buffer_sel,
    output logic       o_frame_done,
    output logic       o_frame_drop
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_SWAP
    } state_t;

    localparam logic [9:0] LAST_COL = 10'(NUM_COLS - 1);
    localparam logic [9:0] MAX_H    = 10'(MAX_HEIGHT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_cnt;
    logic [9:0] w_cnt_nxt;
    logic       r_sel;
    logic       w_sel_nxt;
    logic       w_done_nxt;
    logic       w_drop_nxt;
    logic       w_accept;
    logic       w_last;
    logic [9:0] w_clamped;

    assign w_accept  = i_col_valid & o_col_ready;
    assign w_last    = (r_cnt == LAST_COL);
    assign w_clamped = (i_col_height > MAX_H) ? MAX_H : i_col_height;
    assign o_col_x      = r_cnt;
    assign o_buffer_sel = r_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_done_nxt  = 1'b0;
        w_drop_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_frame_start) begin
                    w_state_nxt = FILL;
                    w_cnt_nxt   = '0;
                end
            end
            FILL: begin
                // A final accept wins over a coincident frame start.
                if (w_accept && w_last) begin
                    w_state_nxt = WAIT_SWAP;
                end else if (i_frame_start) begin
                    w_drop_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                end else if (w_accept) begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            WAIT_SWAP: begin
                if (i_frame_start) begin
                    w_state_nxt = FILL;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = ~r_sel;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sel        <= 1'b0;
            o_col_ready  <= 1'b0;
            o_wr_en1     <= 1'b0;
            o_wr_en2     <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
            o_frame_drop <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sel        <= w_sel_nxt;
            o_col_ready  <= (w_state_nxt == FILL);
            o_wr_en1     <= w_accept & ~r_sel;
            o_wr_en2     <= w_accept & r_sel;
            o_frame_done <= w_done_nxt;
            o_frame_drop <= w_drop_nxt;
            if (w_accept) begin
                o_wr_addr <= r_cnt;
                o_wr_data <= w_clamped;
            end
        end
    end

endmodule

// File: tb/tb_raycast_column_writer.sv
// Randomized bench for raycast_column_writer against a frame-level model.
// Outputs are checked on every falling edge plus literal spot checks.
module tb_raycast_column_writer;

    localparam int NC = 640;
    localparam int MH = 960;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_frame_start;
    logic       i_col_valid;
    logic [9:0] i_col_height;
    logic       o_col_ready;
    logic [9:0] o_col_x;
    logic       o_wr_en1;
    logic       o_wr_en2;
    logic [9:0] o_wr_addr;
    logic [9:0] o_wr_data;
    logic       o_buffer_sel;
    logic       o_frame_done;
    logic       o_frame_drop;

    raycast_column_writer #(.NUM_COLS(NC), .MAX_HEIGHT(MH)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_frame_start(i_frame_start),
        .i_col_valid(i_col_valid),
        .i_col_height(i_col_height),
        .o_col_ready(o_col_ready),
        .o_col_x(o_col_x),
        .o_wr_en1(o_wr_en1),
        .o_wr_en2(o_wr_en2),
        .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data),
        .o_buffer_sel(o_buffer_sel),
        .o_frame_done(o_frame_done),
        .o_frame_drop(o_frame_drop)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_en1 = 0;
    int n_en2 = 0;
    int n_done = 0;

    // Frame-level model: filling / frame complete / idle, column, display
    bit m_filling, m_full;
    int m_col;
    bit m_sel;
    bit e_en1, e_en2, e_done, e_drop;
    int e_addr, e_data;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        m_filling = 0;
        m_full = 0;
        m_col = 0;
        m_sel = 0;
        e_en1 = 0;
        e_en2 = 0;
        e_done = 0;
        e_drop = 0;
        e_addr = 0;
        e_data = 0;
    endtask

    task automatic model_step(input bit fs, input bit v, input int h);
        bit acc;
        acc = v && m_filling;
        e_en1 = acc && !m_sel;
        e_en2 = acc && m_sel;
        e_done = 0;
        e_drop = 0;
        if (acc) begin
            e_addr = m_col;
            e_data = (h > MH) ? MH : h;
        end
        if (m_filling) begin
            if (acc && m_col == NC - 1) begin
                m_filling = 0;
                m_full = 1;
            end else if (fs) begin
                e_drop = 1;
                m_col = 0;
            end else if (acc) begin
                m_col++;
            end
        end else if (m_full) begin
            if (fs) begin
                m_sel = !m_sel;
                e_done = 1;
                m_col = 0;
                m_full = 0;
                m_filling = 1;
            end
        end else if (fs) begin
            m_filling = 1;
            m_col = 0;
        end
    endtask

    task automatic check_all();
        chk("ready", int'(o_col_ready), int'(m_filling));
        chk("col_x", int'(o_col_x), m_col);
        chk("sel", int'(o_buffer_sel), int'(m_sel));
        chk("en1", int'(o_wr_en1), int'(e_en1));
        chk("en2", int'(o_wr_en2), int'(e_en2));
        chk("done", int'(o_frame_done), int'(e_done));
        chk("drop", int'(o_frame_drop), int'(e_drop));
        if (e_en1 || e_en2) begin
            chk("addr", int'(o_wr_addr), e_addr);
            chk("data", int'(o_wr_data), e_data);
        end
        n_en1 += int'(o_wr_en1);
        n_en2 += int'(o_wr_en2);
        n_done += int'(o_frame_done);
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input bit fs, input bit v, input int h);
        i_frame_start = fs;
        i_col_valid = v;
        i_col_height = 10'(h);
        model_step(fs, v, h);
        @(negedge i_clk);
        check_all();
    endtask

    task automatic fill_rand(input int n);
        int got = 0;
        int guard = 0;
        bit v;
        while (got < n && guard < n * 20) begin
            v = ($urandom_range(0, 3) != 0);
            if (v && m_filling) got++;
            step(0, v, int'($urandom_range(0, 1023)));
            guard++;
        end
        chk("fill_budget", got, n);
    endtask

    initial begin
        i_rst = 1'b1;
        i_frame_start = 0;
        i_col_valid = 0;
        i_col_height = 0;
        model_reset();
        repeat (3) @(negedge i_clk);
        check_all();
        chk("rst_addr", int'(o_wr_addr), 0);
        chk("rst_data", int'(o_wr_data), 0);
        i_rst = 1'b0;
        step(0, 1, 5);
        // Frame 1: back-to-back, height = column index
        step(1, 0, 0);
        n_en1 = 0;
        for (int x = 0; x < NC; x++) step(0, 1, x);
        chk("f1_en1_count", n_en1, NC);
        chk("f1_last_addr", int'(o_wr_addr), 639);
        chk("f1_last_data", int'(o_wr_data), 639);
        step(0, 1, 7);
        chk("f1_ready_low", int'(o_col_ready), 0);
        chk("f1_sel_held", int'(o_buffer_sel), 0);
        n_done = 0;
        step(1, 0, 0);
        chk("f1_sel_swap", int'(o_buffer_sel), 1);
        chk("f1_done", int'(o_frame_done), 1);
        step(0, 0, 0);
        chk("f1_done_once", n_done, 1);
        // Frame 2: random stalls, must land on buffer2
        n_en1 = 0;
        n_en2 = 0;
        fill_rand(NC);
        chk("f2_en2_count", n_en2, NC);
        chk("f2_en1_none", n_en1, 0);
        step(1, 0, 0);
        chk("f2_sel_back", int'(o_buffer_sel), 0);
        // Clamp boundaries
        step(0, 1, 959);
        chk("clamp959", int'(o_wr_data), 959);
        step(0, 1, 960);
        chk("clamp960", int'(o_wr_data), 960);
        step(0, 1, 961);
        chk("clamp961", int'(o_wr_data), 960);
        step(0, 1, 1023);
        chk("clamp1023", int'(o_wr_data), 960);
        fill_rand(96);
        chk("pre_drop_x", int'(o_col_x), 100);
        step(1, 0, 0);
        chk("drop_pulse", int'(o_frame_drop), 1);
        chk("drop_x", int'(o_col_x), 0);
        chk("drop_sel", int'(o_buffer_sel), 0);
        fill_rand(NC);
        step(1, 0, 0);
        chk("swap_after_drop", int'(o_buffer_sel), 1);
        // Final accept coinciding with frame start
        fill_rand(NC - 1);
        step(1, 1, 300);
        chk("coinc_drop", int'(o_frame_drop), 0);
        chk("coinc_sel", int'(o_buffer_sel), 1);
        chk("coinc_en2", int'(o_wr_en2), 1);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        chk("coinc_done", int'(o_frame_done), 1);
        chk("coinc_sel_swap", int'(o_buffer_sel), 0);
        // Reset mid-fill at column 300
        fill_rand(300);
        #2;
        i_rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_ready", int'(o_col_ready), 0);
        chk("mid_rst_x", int'(o_col_x), 0);
        chk("mid_rst_sel", int'(o_buffer_sel), 0);
        chk("mid_rst_addr", int'(o_wr_addr), 0);
        @(negedge i_clk);
        check_all();
        i_rst = 1'b0;
        n_en1 = 0;
        n_en2 = 0;
        for (int k = 0; k < 20; k++) step(0, 1, k);
        chk("post_rst_nowrite", n_en1 + n_en2, 0);
        step(1, 0, 0);
        fill_rand(NC);
        chk("post_rst_fill", n_en1, NC);
        repeat (4) step(int'($urandom_range(0, 1)), 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/raycast_column_writer.md
Name: raycast_column_writer

Overview:
- Producer side of the double-buffered column-height store that the raycast pixel renderer reads.
- Accepts one wall height per screen column from the raycaster over a valid/ready stream.
- Writes each height into the back buffer; a full frame is NUM_COLS columns.
- Swaps the front/back select only at the next frame-start pulse, so the renderer never shows a partially written frame.

Parameters:
- NUM_COLS, 640, columns per frame; legal range 2..1023.
- MAX_HEIGHT, 960, saturation limit for written heights. The renderer's half-height is height>>2 around row 240.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_frame_start  input  1  one-cycle pulse from video timing at start of vblank.
- i_col_valid  input  1  raycaster has a height for column o_col_x.
- i_col_height  input  10  wall height; 0 means empty column.
- o_col_ready  output  1  writer accepts a column this cycle.
- o_col_x  output  10  column index the writer expects next.
- o_wr_en1  output  1  write strobe for buffer1.
- o_wr_en2  output  1  write strobe for buffer2.
- o_wr_addr  output  10  write address, equal to the column index.
- o_wr_data  output  10  clamped height.
- o_buffer_sel  output  1  display select; 1 means the renderer reads buffer1.
- o_frame_done  output  1  one-cycle pulse when a swap occurs.
- o_frame_drop  output  1  one-cycle pulse when a frame start aborts an incomplete fill.

Behaviour:
- Reset (async assert, takes effect immediately):
  - state IDLE.
  - col counter 0.
  - o_buffer_sel=0.
  - o_col_ready, o_wr_en1, o_wr_en2, o_frame_done, o_frame_drop all 0.
  - o_wr_addr=0, o_wr_data=0.
- Reset mid-fill discards the partial frame. Buffer contents are not cleared.
- Back buffer is the one not selected for display: buffer1 when o_buffer_sel=0, buffer2 when o_buffer_sel=1.
- Accept = i_col_valid & o_col_ready.
- Write strobe timing:
  - On accept, the next cycle registers o_wr_addr=counter, o_wr_data=min(i_col_height, MAX_HEIGHT) and pulses the back-buffer strobe for exactly one cycle.
  - Back-buffer selection uses o_buffer_sel as of the accept cycle.
  - Latency is 1 cycle. The strobe is 0 on every non-accept cycle.
- o_col_x always equals the counter. It holds while i_col_valid=1 and o_col_ready=0. i_col_height is don't-care when i_col_valid=0.
- o_col_ready is a registered function of state: 1 only in FILL.
- States:
  - IDLE: ready=0. On i_frame_start go to FILL with counter 0. No swap and no done pulse.
  - FILL: ready=1.
    - Accept with counter<NUM_COLS-1: increment counter.
    - Accept with counter==NUM_COLS-1: counter stays at NUM_COLS-1, go to WAIT_SWAP.
    - i_frame_start without a final accept: pulse o_frame_drop, counter to 0, stay in FILL, no swap. A write accepted that same cycle still completes at the old address.
    - Final accept coinciding with i_frame_start: go to WAIT_SWAP, no drop, and that frame_start is ignored. Swap waits for the next pulse.
  - WAIT_SWAP: ready=0. On i_frame_start: toggle o_buffer_sel, pulse o_frame_done, counter to 0, go to FILL.
- o_frame_done and o_frame_drop are registered and appear the cycle after the triggering frame_start edge. o_buffer_sel toggles on that same edge.
- Clamp compares full 10-bit unsigned values. Heights above MAX_HEIGHT write MAX_HEIGHT.
- Counter never exceeds NUM_COLS-1, so no wrap beyond it.

Test Plan:
- Reset, then one i_frame_start, then NUM_COLS=640 back-to-back valid columns with height=x -> o_wr_en1 pulses 640 times, addr 0..639, data 0..639. Ready drops after col 639. o_buffer_sel stays 0 until the next frame_start, then becomes 1 and o_frame_done pulses once.
- Second frame after swap -> writes appear only on o_wr_en2. A following frame_start returns o_buffer_sel to 0.
- Heights 959, 960, 961, 1023 -> o_wr_data 959, 960, 960, 960.
- i_frame_start after 100 columns accepted -> o_frame_drop pulses, o_col_x returns to 0, o_buffer_sel unchanged. Next full fill then swaps normally.
- Final-column accept in the same cycle as i_frame_start -> no drop, no swap. Swap and done occur only on the following frame_start.
- Assert i_rst mid-fill (col 300) -> outputs return to reset values immediately. After release, nothing is written until i_frame_start. Valid held high with random stalls (valid toggling) -> no duplicate or skipped addresses.
